// File: rtl/pwm_capture_if.sv
// Signal bundle for pwm_capture: the raw PWM input and the measurement results.
interface pwm_capture_if;
  logic        pwm_in;
  logic [27:0] high_cnt;
  logic [27:0] period_cnt;
  logic [7:0]  position;
  logic        valid;
  logic        timeout;

  modport slave (
    input  pwm_in,
    output high_cnt, period_cnt, position, valid, timeout
  );

  modport master (
    output pwm_in,
    input  high_cnt, period_cnt, position, valid, timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and decodes a servo-style
// position from the high time. States: IDLE = waiting for first rise, HIGH = counting
// high time, LOW = counting remainder of period until the closing rise.
module pwm_capture #(
  parameter logic [27:0] OFFSET  = 28'd50000,
  parameter logic [27:0] STEP    = 28'd273,
  parameter logic [27:0] TIMEOUT = 28'd2000000
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        s_q, s_d;
  logic        s_dly_q, s_dly_d;
  logic [27:0] cnt_q, cnt_d;
  logic [27:0] hcnt_q, hcnt_d;
  logic [27:0] presc_q, presc_d;
  logic [7:0]  pos_acc_q, pos_acc_d;
  logic [27:0] high_cnt_q, high_cnt_d;
  logic [27:0] period_cnt_q, period_cnt_d;
  logic [7:0]  position_q, position_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic        rise, fall;
  logic [27:0] hcnt_inc;

  assign rise     = s_q & ~s_dly_q;
  assign fall     = ~s_q & s_dly_q;
  assign hcnt_inc = hcnt_q + 28'd1;

  always_comb begin
    state_d      = state_q;
    sync1_d      = bus.pwm_in;
    s_d          = sync1_q;
    s_dly_d      = s_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    presc_d      = presc_q;
    pos_acc_d    = pos_acc_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    position_d   = position_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = HIGH;
          cnt_d     = 28'd1;
          hcnt_d    = 28'd1;
          presc_d   = 28'd1;
          pos_acc_d = 8'd0;
        end
      end

      HIGH: begin
        // Abort before a fall could push cnt past TIMEOUT.
        if (cnt_q == TIMEOUT) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (fall) begin
          state_d = LOW;
          cnt_d   = cnt_q + 28'd1;
        end else begin
          cnt_d  = cnt_q + 28'd1;
          hcnt_d = hcnt_inc;
          // Prescaler replaces a divide: one position LSB per STEP cycles past OFFSET.
          if (hcnt_inc > OFFSET && pos_acc_q != 8'd255) begin
            if (presc_q == STEP) begin
              presc_d   = 28'd1;
              pos_acc_d = pos_acc_q + 8'd1;
            end else begin
              presc_d = presc_q + 28'd1;
            end
          end
        end
      end

      LOW: begin
        if (rise) begin
          period_cnt_d = cnt_q;
          high_cnt_d   = hcnt_q;
          position_d   = pos_acc_q;
          valid_d      = 1'b1;
          timeout_d    = 1'b0;
          state_d      = HIGH;
          cnt_d        = 28'd1;
          hcnt_d       = 28'd1;
          presc_d      = 28'd1;
          pos_acc_d    = 8'd0;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 28'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      s_q          <= 1'b0;
      s_dly_q      <= 1'b0;
      cnt_q        <= 28'd0;
      hcnt_q       <= 28'd0;
      presc_q      <= 28'd0;
      pos_acc_q    <= 8'd0;
      high_cnt_q   <= 28'd0;
      period_cnt_q <= 28'd0;
      position_q   <= 8'd0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      s_q          <= s_d;
      s_dly_q      <= s_dly_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      presc_q      <= presc_d;
      pos_acc_q    <= pos_acc_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      position_q   <= position_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.high_cnt   = high_cnt_q;
  assign bus.period_cnt = period_cnt_q;
  assign bus.position   = position_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture with scaled-down timing parameters.
module tb_pwm_capture;
  localparam int OFF = 40;
  localparam int STP = 3;
  localparam int TMO = 1500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_capture_if bus ();

  pwm_capture #(
    .OFFSET (28'(OFF)),
    .STEP   (28'(STP)),
    .TIMEOUT(28'(TMO))
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit is_to;
    int h;
    int p;
    int pos;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Model state: pulse awaiting its closing rise, sticky timeout, last published values.
  bit pend = 0;
  int pend_h, pend_p;
  bit m_to = 0;
  int last_h = 0, last_p = 0, last_pos = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_pos(input int h);
    int v;
    if (h <= OFF) return 0;
    v = (h - OFF) / STP;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rise();
    exp_t e;
    if (pend) begin
      e.is_to = 0; e.h = pend_h; e.p = pend_p; e.pos = ref_pos(pend_h);
      q.push_back(e);
      m_to = 0;
      last_h = e.h; last_p = e.p; last_pos = e.pos;
      pend = 0;
    end
    bus.pwm_in = 1'b1;
  endtask

  task automatic send_pulse(input int h, input int p);
    exp_t e;
    do_rise();
    if (h >= TMO || p > TMO) begin
      if (!m_to) begin
        e.is_to = 1; e.h = last_h; e.p = last_p; e.pos = last_pos;
        q.push_back(e);
        m_to = 1;
      end
    end else begin
      pend = 1; pend_h = h; pend_p = p;
    end
    wait_cycles(h);
    bus.pwm_in = 1'b0;
    wait_cycles(p - h);
  endtask

  logic to_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      to_prev <= 1'b0;
    end else begin
      if (bus.valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("valid_kind", int'(e.is_to), 0);
          check("high_cnt", int'(bus.high_cnt), e.h);
          check("period_cnt", int'(bus.period_cnt), e.p);
          check("position", int'(bus.position), e.pos);
          check("timeout_cleared", int'(bus.timeout), 0);
        end
      end
      if (bus.timeout && !to_prev) begin
        if (q.size() == 0) begin
          check("unexpected_timeout", 1, 0);
        end else begin
          e = q.pop_front();
          check("timeout_kind", int'(e.is_to), 1);
          check("to_hold_high", int'(bus.high_cnt), e.h);
          check("to_hold_period", int'(bus.period_cnt), e.p);
          check("to_hold_pos", int'(bus.position), e.pos);
        end
      end
      to_prev <= bus.timeout;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_high"}, int'(bus.high_cnt), 0);
    check({tag, "_period"}, int'(bus.period_cnt), 0);
    check({tag, "_pos"}, int'(bus.position), 0);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_timeout"}, int'(bus.timeout), 0);
  endtask

  initial begin
    int h, p;
    bus.pwm_in = 1'b0;
    rst_n = 1'b0;
    wait_cycles(5);
    check_zero("reset");
    rst_n = 1'b1;
    wait_cycles(3);

    // Nominal: three periods, position 100.
    repeat (3) send_pulse(OFF + STP * 100, 1000);
    send_pulse(20, 1000);             // below OFFSET
    send_pulse(900, 1000);            // saturates
    send_pulse(OFF, 1000);
    send_pulse(OFF + STP - 1, 300);
    send_pulse(OFF + STP, 300);
    send_pulse(OFF + STP * 255 - 1, 1000);
    send_pulse(OFF + STP * 255, 1000);
    send_pulse(10, 11);               // one-cycle low phase
    send_pulse(TMO - 1, TMO);         // longest accepted measurement

    // Stuck high, then recovery at position 50.
    send_pulse(OFF + STP * 100, 1000);
    send_pulse(TMO + 100, TMO + 200);
    send_pulse(OFF + STP * 50, 1000);
    send_pulse(OFF + STP * 50, 1000);
    send_pulse(100, TMO + 1);         // period one past the limit
    send_pulse(OFF + STP * 10, 1000);

    // Reset in the middle of a high phase discards the measurement.
    do_rise();
    wait_cycles(30);
    rst_n = 1'b0;
    bus.pwm_in = 1'b0;
    #2;
    check_zero("midreset");
    pend = 0; m_to = 0; last_h = 0; last_p = 0; last_pos = 0;
    wait_cycles(4);
    check_zero("midreset_hold");
    rst_n = 1'b1;
    wait_cycles(3);
    send_pulse(OFF + STP * 100, 1000);
    send_pulse(OFF + STP * 100, 1000);

    for (int i = 0; i < 40; i++) begin
      h = int'($urandom_range(1600, 1));
      p = h + int'($urandom_range(300, 1));
      send_pulse(h, p);
    end

    do_rise();
    wait_cycles(20);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter OFFSET, default 28'd50000, giving the high-time in clk cycles that maps to position 0.
REQ-002 SHALL have parameter STEP, default 28'd273, giving the clk cycles of high-time per position LSB.
REQ-003 SHALL have parameter TIMEOUT, default 28'd2000000, giving the clk cycles without an expected edge before the block aborts; legal range is 2 .. 2^28-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port pwm_in, input, 1 bit: asynchronous PWM pulse train to be measured.
REQ-007 SHALL have port high_cnt, output, 28 bits: last measured high time in clk cycles.
REQ-008 SHALL have port period_cnt, output, 28 bits: last measured period in clk cycles.
REQ-009 SHALL have port position, output, 8 bits: last decoded position.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle strobe marking an output update.
REQ-011 SHALL have port timeout, output, 1 bit: sticky flag for a missing edge.

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer to form s, and register s as s_d; all logic uses s only.
REQ-013 SHALL treat s=1, s_d=0 as a rising edge (rise) and s=0, s_d=1 as a falling edge (fall).
REQ-014 SHALL implement states IDLE, HIGH and LOW; IDLE is the reset state.
REQ-015 IDLE SHALL go to HIGH on rise, with cnt=1, hcnt=1, prescaler=1 and pos_acc=0.
REQ-016 HIGH SHALL increment cnt and hcnt each cycle while s=1, and SHALL go to LOW on fall with cnt incremented and hcnt frozen.
REQ-017 LOW SHALL increment cnt each cycle while s=0.
REQ-018 On rise in LOW, the block SHALL set period_cnt=cnt, high_cnt=hcnt, position=pos_acc, pulse valid=1 for one cycle and clear timeout.
REQ-019 That same rise SHALL restart the measurement, so back-to-back periods are measured with no gap.
REQ-020 Across one measurement, pos_acc SHALL equal min(255, floor(max(0, hcnt-OFFSET)/STEP)).
REQ-021 pos_acc SHALL be computed incrementally while in HIGH: once hcnt exceeds OFFSET, a prescaler counts STEP cycles per pos_acc increment, and pos_acc saturates at 255.
REQ-022 pos_acc SHALL be computed with no divider; the result is final at the fall.
REQ-023 If cnt reaches TIMEOUT in HIGH or LOW without the expected edge, the block SHALL go to IDLE and set timeout=1.
REQ-024 On timeout, high_cnt, period_cnt and position SHALL hold their previous values, and no valid pulse is issued.
REQ-025 A rise and a timeout in the same cycle SHALL be resolved with rise taking priority.
REQ-026 Latency SHALL be: valid is asserted 3 clk cycles after the pwm_in rising edge that closes the period (2 cycles synchronizer plus 1 cycle register).
REQ-027 The first rise after reset or after a timeout SHALL only start a measurement and produce no valid.
REQ-028 cnt SHALL never exceed TIMEOUT, so no 28-bit wrap-around can occur.

Reset
REQ-029 On rst_n=0, regardless of clk, the block SHALL force state=IDLE, synchronizer=0, s_d=0, all counters=0, high_cnt=0, period_cnt=0, position=0, valid=0 and timeout=0.
REQ-030 Reset asserted mid-measurement SHALL discard the partial measurement.
REQ-031 After rst_n rises, the first measurement SHALL complete no earlier than the second rise seen on s.

Verification
REQ-032 Drive a 1,000,000-cycle period with 77,300 high for 3 periods: expect valid on the 2nd and 3rd rises, with high_cnt=77300, period_cnt=1000000 and position=100.
REQ-033 Drive high=40,000 with period 1,000,000: expect position=0 and high_cnt=40000.
REQ-034 Drive high=200,000 with period 1,000,000: expect position=255 (saturated) and high_cnt=200000.
REQ-035 Drive a 1,000,000-cycle period with 77,300 high, then hold pwm_in high for 2,100,000 cycles: expect timeout=1 at hcnt=2,000,000, no valid, and outputs holding position=100.
REQ-036 Then resume a 1,000,000-cycle period with 63,650 high: expect the first rise to give no valid, the next rise to give position=50, and timeout to clear.
REQ-037 Pulse rst_n low during a HIGH phase, then run 2 periods of 1,000,000 cycles with 77,300 high: expect all outputs=0 during reset and exactly one valid, with correct values.
